mult_booth_seq: RTL and testbench

- Sequencer directly upstream of the radix-4 Booth step stage.
- Accepts a multiply request and builds the initial 65-bit product vector.
- Feeds the step stage for ITERATIONS clock cycles, then captures the final product.
- Reports a 32-bit result, overflow exception and a one-cycle ready pulse to the multdiv top level.

---
 rtl/mult_booth_seq_if.sv | 27 ++
 rtl/mult_booth_seq.sv | 105 ++++++++++
 tb/tb_mult_booth_seq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mult_booth_seq_if.sv
// Request/result and Booth step-stage signals for mult_booth_seq.
// The slave modport is the sequencer. The master modport is the multdiv top plus the step stage.
`timescale 1ns/1ps
interface mult_booth_seq_if;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [64:0] step_prev_product;
  logic [31:0] step_multiplicand;
  logic [64:0] step_product;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  modport slave (
    input  ctrl_MULT, data_operandA, data_operandB, step_product,
    output step_prev_product, step_multiplicand,
           data_result, data_exception, data_resultRDY, busy
  );

  modport master (
    output ctrl_MULT, data_operandA, data_operandB, step_product,
    input  step_prev_product, step_multiplicand,
           data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/mult_booth_seq.sv
// Sequencer for an external radix-4 Booth step stage. It seeds the product vector,
// runs ITERATIONS steps and captures the signed product. Optional macro: MULT_EARLY_ZERO_EN.
`timescale 1ns/1ps
module mult_booth_seq #(
  parameter int ITERATIONS = 16
) (
  input logic            clock,
  input logic            clear,
  mult_booth_seq_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [4:0] LAST = 5'(ITERATIONS);

  state_t      r_state;
  state_t      w_nextState;
  logic [4:0]  r_count;
  logic [4:0]  w_nextCount;
  logic [31:0] r_mcand;
  logic [31:0] r_result;
  logic        r_exception;
  logic        r_resultRdy;

  logic        w_start;
  logic        w_zeroOp;
  logic        w_loadMcand;
  logic        w_capture;
  logic        w_earlyZero;
  logic        w_overflow;

  assign w_start = bus.ctrl_MULT;

`ifdef MULT_EARLY_ZERO_EN
  assign w_zeroOp = (bus.data_operandA == 32'd0) || (bus.data_operandB == 32'd0);
`else
  assign w_zeroOp = 1'b0;
`endif

  // The upper word must be pure sign extension of bit 32 for the product to fit in 32 bits.
  assign w_overflow = (bus.step_product[64:33] != {32{bus.step_product[32]}});

  assign bus.step_prev_product = w_start ? {32'd0, bus.data_operandB, 1'b0} : bus.step_product;
  assign bus.step_multiplicand = w_start ? bus.data_operandA : r_mcand;

  always_ff @(posedge clock) begin
    if (clear) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // A start in any state restarts the sequence. Otherwise RUN counts until the last step is visible.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_loadMcand = 1'b0;
    w_capture   = 1'b0;
    w_earlyZero = 1'b0;
    if (w_start) begin
      w_loadMcand = 1'b1;
      if (w_zeroOp) begin
        w_earlyZero = 1'b1;
        w_nextState = IDLE;
        w_nextCount = 5'd0;
      end else begin
        w_nextState = RUN;
        w_nextCount = 5'd1;
      end
    end else if (r_state == RUN) begin
      if (r_count == LAST) begin
        w_capture   = 1'b1;
        w_nextState = IDLE;
        w_nextCount = 5'd0;
      end else begin
        w_nextCount = r_count + 5'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_count     <= 5'd0;
      r_mcand     <= 32'd0;
      r_result    <= 32'd0;
      r_exception <= 1'b0;
      r_resultRdy <= 1'b0;
    end else begin
      r_count     <= w_nextCount;
      r_resultRdy <= w_capture | w_earlyZero;
      if (w_loadMcand) r_mcand <= bus.data_operandA;
      if (w_capture) begin
        r_result    <= bus.step_product[32:1];
        r_exception <= w_overflow;
      end else if (w_earlyZero) begin
        r_result    <= 32'd0;
        r_exception <= 1'b0;
      end
    end
  end

  assign bus.data_result    = r_result;
  assign bus.data_exception = r_exception;
  assign bus.data_resultRDY = r_resultRdy;
  assign bus.busy           = (r_state == RUN);

endmodule

// File: tb/tb_mult_booth_seq.sv
// Directed bench for mult_booth_seq. A behavioural radix-4 Booth step stage is included,
// and its output is registered with one clock of latency.
`timescale 1ns/1ps
module tb_mult_booth_seq;

  logic clock = 1'b0;
  logic clear;
  int   errorCount = 0;
  int   checkCount = 0;

  mult_booth_seq_if bus();

  mult_booth_seq #(.ITERATIONS(16)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // One radix-4 Booth step. The 34-bit accumulator keeps the +/-2M term exact before the shift.
  function automatic logic [64:0] boothStep(input logic [64:0] p, input logic [31:0] m);
    logic signed [33:0] acc;
    logic signed [33:0] addend;
    logic signed [66:0] wide;
    acc = {{2{p[64]}}, p[64:33]};
    case (p[2:0])
      3'b001, 3'b010: addend = {{2{m[31]}}, m};
      3'b011:         addend = {m[31], m, 1'b0};
      3'b100:         addend = -{m[31], m, 1'b0};
      3'b101, 3'b110: addend = -{{2{m[31]}}, m};
      default:        addend = 34'sd0;
    endcase
    acc  = acc + addend;
    wide = {acc, p[32:0]};
    wide = wide >>> 2;
    return wide[64:0];
  endfunction

  initial bus.step_product = 65'd0;
  always @(posedge clock) bus.step_product <= boothStep(bus.step_prev_product, bus.step_multiplicand);

  task automatic checkOutput(input string tag, input logic [64:0] observed, input logic [64:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Holds ctrl_MULT for one cycle (cycle 0). The task returns at the sample point of cycle 1.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
  endtask

  task automatic waitResult(input string tag, input int expCycle, input logic [31:0] expRes,
                            input logic expExc, input int expBusy);
    int          firstCycle = -1;
    int          pulses     = 0;
    int          busyCycles = 0;
    logic [31:0] resSeen    = 32'hDEADBEEF;
    logic        excSeen    = 1'bx;
    for (int c = 1; c <= 24; c++) begin
      if (bus.busy) busyCycles++;
      if (bus.data_resultRDY) begin
        pulses++;
        if (firstCycle < 0) begin
          firstCycle = c;
          resSeen    = bus.data_result;
          excSeen    = bus.data_exception;
        end
      end
      @(negedge clock);
    end
    checkOutput({tag, ".cycle"},  65'(firstCycle), 65'(expCycle));
    checkOutput({tag, ".pulses"}, 65'(pulses), 65'd1);
    checkOutput({tag, ".result"}, 65'(resSeen), 65'(expRes));
    checkOutput({tag, ".exc"},    65'(excSeen), 65'(expExc));
    checkOutput({tag, ".busy"},   65'(busyCycles), 65'(expBusy));
    checkOutput({tag, ".hold"},   65'(bus.data_result), 65'(expRes));
  endtask

  // Samples for n cycles and counts ready pulses and busy cycles.
  task automatic idleWatch(input int n, output int pulses, output int busyCycles);
    pulses = 0;
    busyCycles = 0;
    for (int c = 0; c < n; c++) begin
      if (bus.data_resultRDY) pulses++;
      if (bus.busy) busyCycles++;
      @(negedge clock);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int pulses;
    int busyCycles;
    int zeroCycle;
    int zeroBusy;
    clear = 1'b1;
    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = 32'd0;
    bus.data_operandB = 32'd0;
    repeat (3) @(negedge clock);
    checkOutput("reset.result", 65'(bus.data_result), 65'd0);
    checkOutput("reset.exc",    65'(bus.data_exception), 65'd0);
    checkOutput("reset.rdy",    65'(bus.data_resultRDY), 65'd0);
    checkOutput("reset.busy",   65'(bus.busy), 65'd0);
    clear = 1'b0;
    @(negedge clock);

    applyStimulus(32'd3, 32'd5);
    waitResult("m3x5", 17, 32'd15, 1'b0, 16);
    applyStimulus(32'hFFFFFFF9, 32'd6);
    waitResult("mNeg7x6", 17, 32'hFFFFFFD6, 1'b0, 16);
    applyStimulus(32'hFFFFFFF8, 32'hFFFFFFF8);
    waitResult("mNeg8xNeg8", 17, 32'd64, 1'b0, 16);
    applyStimulus(32'h00010000, 32'h00010000);
    waitResult("m2p16sq", 17, 32'h00000000, 1'b1, 16);
    applyStimulus(32'h7FFFFFFF, 32'd1);
    waitResult("mMaxx1", 17, 32'h7FFFFFFF, 1'b0, 16);
    applyStimulus(32'h80000000, 32'hFFFFFFFF);
    waitResult("mMinxNeg1", 17, 32'h80000000, 1'b1, 16);
    applyStimulus(32'h80000000, 32'd1);
    waitResult("mMinx1", 17, 32'h80000000, 1'b0, 16);

    // Restart at cycle 8: the first operation must never complete.
    applyStimulus(32'd3, 32'd5);
    idleWatch(7, pulses, busyCycles);
    checkOutput("restart.prePulses", 65'(pulses), 65'd0);
    checkOutput("restart.preBusy",   65'(busyCycles), 65'd7);
    applyStimulus(32'd4, 32'd4);
    waitResult("restart", 17, 32'd16, 1'b0, 16);

    // Clear at cycle 10 aborts and zeroes the held result.
    applyStimulus(32'd9, 32'd9);
    repeat (9) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    checkOutput("abort.busy", 65'(bus.busy), 65'd0);
    checkOutput("abort.result", 65'(bus.data_result), 65'd0);
    idleWatch(20, pulses, busyCycles);
    checkOutput("abort.pulses", 65'(pulses), 65'd0);
    checkOutput("abort.busyCycles", 65'(busyCycles), 65'd0);
    checkOutput("abort.exc", 65'(bus.data_exception), 65'd0);

    // clear and ctrl_MULT together: clear wins.
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = 32'd5;
    bus.data_operandB = 32'd5;
    clear = 1'b1;
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    clear = 1'b0;
    idleWatch(20, pulses, busyCycles);
    checkOutput("clrStart.pulses", 65'(pulses), 65'd0);
    checkOutput("clrStart.busy",   65'(busyCycles), 65'd0);

`ifdef MULT_EARLY_ZERO_EN
    zeroCycle = 1;
    zeroBusy  = 0;
`else
    zeroCycle = 17;
    zeroBusy  = 16;
`endif
    applyStimulus(32'd0, 32'd123);
    waitResult("zeroA", zeroCycle, 32'd0, 1'b0, zeroBusy);
    applyStimulus(32'd7, 32'd3);
    waitResult("m7x3", 17, 32'd21, 1'b0, 16);
    applyStimulus(32'd77, 32'd0);
    waitResult("zeroB", zeroCycle, 32'd0, 1'b0, zeroBusy);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
